// File: rtl/sd_cmd_pkg.sv
// Shared constants, state encoding and CRC7 step for the SD CMD-line responder.
// Bit positions are numbered from the frame MSB (start bit = 47) down to the end bit (0).
package sd_cmd_pkg;

  localparam int         FRAME_LEN = 48;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RX       = 2'd1,
    WAIT_RSP = 2'd2,
    TX       = 2'd3
  } state_t;

  localparam logic [5:0] START_POS = 6'd47;
  localparam logic [5:0] DIR_POS   = 6'd46;
  localparam logic [5:0] IDX_MSB   = 6'd45;
  localparam logic [5:0] IDX_LSB   = 6'd40;
  localparam logic [5:0] ARG_MSB   = 6'd39;
  localparam logic [5:0] ARG_LSB   = 6'd8;
  localparam logic [5:0] CRC_MSB   = 6'd7;
  localparam logic [5:0] CRC_LSB   = 6'd1;
  localparam logic [5:0] END_POS   = 6'd0;

  // One serial step of x^7 + x^3 + 1, MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator. clear with enable restarts the sum with data_in as
// the first bit; clear alone zeroes it.
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_in,
  output logic [6:0] crc
);

  logic [6:0] base;

  assign base = clear ? 7'h00 : crc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      crc <= 7'h00;
    else if (clear || enable)
      crc <= enable ? crc7_step(base, data_in) : 7'h00;
  end

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands, hands them to a
// local controller and transmits its response. Optional macro: SD_CMD_RSP_TIMEOUT_EN.
module sd_cmd_responder
  import sd_cmd_pkg::*;
#(
  parameter int NCR     = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_clk_en,
  input  logic        cmd_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        cmd_crc_err,
  output logic        cmd_frame_err,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [5:0]  rsp_index,
  input  logic [31:0] rsp_payload,
  output logic        busy,
  output logic        rsp_timeout
);

  localparam logic [6:0] NCR_MIN = 7'(NCR);

  state_t      state;
  logic [5:0]  bit_cnt;
  logic [5:0]  tx_cnt;
  logic [6:0]  ncr_cnt;
  logic        have_rsp;
  logic [45:0] rx_sr;
  logic [39:0] tx_word;
  logic [6:0]  crc;
  logic        crc_clr;
  logic        crc_en;
  logic        crc_din;

  logic [46:0] rx_frame;
  logic        rx_last;
  logic        hs;
  logic [6:0]  ncr_next;
  logic        tx_start;
  logic [5:0]  tx_pos;
  logic [2:0]  crc_sel;
  logic        tx_bit;

`ifdef SD_CMD_RSP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_next;
  logic            to_pulse;
  logic            to_hit;
  assign to_next     = to_cnt + 1'b1;
  assign to_hit      = sd_clk_en && !have_rsp && !hs && (to_next == TO_W'(TIMEOUT));
  assign rsp_timeout = to_pulse;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Live frame view: the 46 buffered bits plus the bit on the line this strobe.
  assign rx_frame = {rx_sr, cmd_in};
  assign rx_last  = (state == RX) && sd_clk_en && (bit_cnt == END_POS);
  assign hs       = rsp_valid && rsp_ready;
  assign ncr_next = (ncr_cnt == 7'h7F) ? ncr_cnt : ncr_cnt + 7'd1;
  assign tx_start = (state == WAIT_RSP) && sd_clk_en && have_rsp && (ncr_next >= NCR_MIN);
  assign busy     = (state != IDLE);

  // tx_cnt is the position currently on the line; the next strobe moves to tx_pos.
  assign tx_pos  = tx_cnt - 6'd1;
  assign crc_sel = 3'(tx_pos - CRC_LSB);

  always_comb begin
    tx_bit = 1'b1;
    if (tx_pos >= ARG_LSB)
      tx_bit = tx_word[tx_pos - ARG_LSB];
    else if (tx_pos >= CRC_LSB)
      tx_bit = crc[crc_sel];
  end

  always_comb begin
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_din = 1'b0;
    case (state)
      IDLE: begin
        if (sd_clk_en && !cmd_in) begin
          crc_clr = 1'b1;
          crc_en  = 1'b1;
        end
      end
      RX: begin
        if (sd_clk_en && (bit_cnt >= ARG_LSB)) begin
          crc_en  = 1'b1;
          crc_din = cmd_in;
        end
      end
      WAIT_RSP: begin
        if (tx_start) begin
          crc_clr = 1'b1;
          crc_en  = 1'b1;
        end
      end
      TX: begin
        if (sd_clk_en && (tx_cnt != 6'd0) && (tx_pos >= ARG_LSB)) begin
          crc_en  = 1'b1;
          crc_din = tx_bit;
        end
      end
      default: ;
    endcase
  end

  sd_crc7 u_crc (
    .clk     (clk),
    .reset   (reset),
    .clear   (crc_clr),
    .enable  (crc_en),
    .data_in (crc_din),
    .crc     (crc)
  );

  // Datapath stage: receive shift register and latched response word.
  always_ff @(posedge clk) begin
    if ((state == RX) && sd_clk_en)
      rx_sr <= {rx_sr[44:0], cmd_in};
    if (hs)
      tx_word <= {2'b00, rsp_index, rsp_payload};
  end

  // Control stage: line FSM, handshake and command registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= 6'd0;
      tx_cnt        <= 6'd0;
      ncr_cnt       <= 7'd0;
      have_rsp      <= 1'b0;
      rsp_ready     <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_index     <= 6'd0;
      cmd_arg       <= 32'd0;
      cmd_crc_err   <= 1'b0;
      cmd_frame_err <= 1'b0;
      cmd_oe        <= 1'b0;
      cmd_out       <= 1'b1;
`ifdef SD_CMD_RSP_TIMEOUT_EN
      to_cnt        <= '0;
      to_pulse      <= 1'b0;
`endif
    end else begin
      cmd_valid <= 1'b0;
`ifdef SD_CMD_RSP_TIMEOUT_EN
      to_pulse  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (sd_clk_en && !cmd_in) begin
            state   <= RX;
            bit_cnt <= DIR_POS;
          end
        end

        RX: begin
          if (sd_clk_en)
            bit_cnt <= bit_cnt - 6'd1;
          if (rx_last) begin
            if (!rx_frame[DIR_POS]) begin
              // Another card's response on a shared line: not ours to answer.
              state <= IDLE;
            end else begin
              cmd_index     <= rx_frame[IDX_MSB:IDX_LSB];
              cmd_arg       <= rx_frame[ARG_MSB:ARG_LSB];
              cmd_crc_err   <= (rx_frame[CRC_MSB:CRC_LSB] != crc);
              cmd_frame_err <= !rx_frame[END_POS];
              cmd_valid     <= 1'b1;
              if ((rx_frame[CRC_MSB:CRC_LSB] != crc) || !rx_frame[END_POS]) begin
                state <= IDLE;
              end else begin
                state     <= WAIT_RSP;
                rsp_ready <= 1'b1;
                have_rsp  <= 1'b0;
                ncr_cnt   <= 7'd0;
`ifdef SD_CMD_RSP_TIMEOUT_EN
                to_cnt    <= '0;
`endif
              end
            end
          end
        end

        WAIT_RSP: begin
          if (hs) begin
            rsp_ready <= 1'b0;
            have_rsp  <= 1'b1;
          end
          if (sd_clk_en)
            ncr_cnt <= ncr_next;
`ifdef SD_CMD_RSP_TIMEOUT_EN
          if (sd_clk_en)
            to_cnt <= to_next;
`endif
          if (tx_start) begin
            state   <= TX;
            cmd_oe  <= 1'b1;
            cmd_out <= 1'b0;
            tx_cnt  <= START_POS;
          end
`ifdef SD_CMD_RSP_TIMEOUT_EN
          else if (to_hit) begin
            state     <= IDLE;
            rsp_ready <= 1'b0;
            to_pulse  <= 1'b1;
          end
`endif
        end

        TX: begin
          if (sd_clk_en) begin
            if (tx_cnt == END_POS) begin
              state   <= IDLE;
              cmd_oe  <= 1'b0;
              cmd_out <= 1'b1;
            end else begin
              cmd_out <= tx_bit;
              tx_cnt  <= tx_pos;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed bench for sd_cmd_responder; with SD_CMD_RSP_TIMEOUT_EN it also
// exercises the response timeout at TIMEOUT=8.
module tb_sd_cmd_responder;
  import sd_cmd_pkg::*;

`ifdef SD_CMD_RSP_TIMEOUT_EN
  localparam int LATE = 6;
`else
  localparam int LATE = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sd_clk_en;
  logic        cmd_in;
  logic        cmd_out;
  logic        cmd_oe;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_crc_err;
  logic        cmd_frame_err;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [5:0]  rsp_index;
  logic [31:0] rsp_payload;
  logic        busy;
  logic        rsp_timeout;

  sd_cmd_responder #(
    .NCR     (2),
    .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sd_clk_en     (sd_clk_en),
    .cmd_in        (cmd_in),
    .cmd_out       (cmd_out),
    .cmd_oe        (cmd_oe),
    .cmd_valid     (cmd_valid),
    .cmd_index     (cmd_index),
    .cmd_arg       (cmd_arg),
    .cmd_crc_err   (cmd_crc_err),
    .cmd_frame_err (cmd_frame_err),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_index     (rsp_index),
    .rsp_payload   (rsp_payload),
    .busy          (busy),
    .rsp_timeout   (rsp_timeout)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          strobe_no = 0;
  int          vld_cnt, to_cnt, to_at, oe_cnt, first_oe, end_at;
  logic        rdy_seen;
  logic [47:0] cap;
  logic [5:0]  v_idx;
  logic [31:0] v_arg;
  logic        v_crc, v_frm;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clr();
    vld_cnt = 0; to_cnt = 0; to_at = 0; oe_cnt = 0; first_oe = 0;
    rdy_seen = 1'b0; cap = '0; v_idx = '0; v_arg = '0; v_crc = 1'b0; v_frm = 1'b0;
  endtask

  // Called at a negedge; one strobe clk followed by two quiet clks.
  task automatic strobe(input logic b);
    cmd_in = b;
    sd_clk_en = 1'b1;
    @(negedge clk);
    sd_clk_en = 1'b0;
    strobe_no++;
    if (cmd_valid) begin
      vld_cnt++;
      v_idx = cmd_index; v_arg = cmd_arg; v_crc = cmd_crc_err; v_frm = cmd_frame_err;
    end
    if (rsp_timeout) begin to_cnt++; to_at = strobe_no; end
    if (rsp_ready) rdy_seen = 1'b1;
    if (cmd_oe) begin
      cap = {cap[46:0], cmd_out};
      oe_cnt++;
      if (oe_cnt == 1) first_oe = strobe_no;
    end
    repeat (2) begin
      @(negedge clk);
      if (cmd_valid) vld_cnt++;
      if (rsp_timeout) to_cnt++;
      if (rsp_ready) rdy_seen = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) strobe(f[i]);
    end_at = strobe_no;
  endtask

  task automatic idle(input int n);
    repeat (n) strobe(1'b1);
  endtask

  task automatic respond(input logic [5:0] idx, input logic [31:0] pay);
    rsp_index = idx;
    rsp_payload = pay;
    rsp_valid = 1'b1;
    check("rdy_before_hs", rsp_ready, 1);
    @(negedge clk);
    rsp_valid = 1'b0;
    check("rdy_after_hs", rsp_ready, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [47:0] f;
    reset = 1'b1; sd_clk_en = 1'b0; cmd_in = 1'b1; rsp_valid = 1'b0;
    rsp_index = '0; rsp_payload = '0;
    clr();
    repeat (2) @(negedge clk);
    check("rst_oe", cmd_oe, 0);
    check("rst_out", cmd_out, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", rsp_ready, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_index", cmd_index, 0);
    check("rst_arg", cmd_arg, 0);
    reset = 1'b0;
    @(negedge clk);

    // CMD0, immediate response: start bit two strobes after the end bit
    clr();
    send_frame(48'h40_0000_0000_95);
    check("cmd0_valid", vld_cnt, 1);
    check("cmd0_index", v_idx, 6'h00);
    check("cmd0_arg", v_arg, 32'h0);
    check("cmd0_crc", v_crc, 0);
    check("cmd0_frm", v_frm, 0);
    respond(6'h3F, 32'h0);
    idle(52);
    check("cmd0_ncr", first_oe - end_at, 2);
    check("cmd0_startdir", cap[47:46], 2'b00);
    check("cmd0_oe_len", oe_cnt, 48);
    check("cmd0_idle", busy, 0);

    // CMD8 with a late response: start bit on the first strobe after handshake
    clr();
    send_frame(48'h48_0000_01AA_87);
    check("cmd8_valid", vld_cnt, 1);
    check("cmd8_index", v_idx, 6'h08);
    check("cmd8_arg", v_arg, 32'h0000_01AA);
    check("cmd8_crc", v_crc, 0);
    idle(LATE);
    check("cmd8_no_tx_yet", oe_cnt, 0);
    respond(6'h08, 32'h0000_01AA);
    idle(52);
    check("cmd8_late", first_oe - end_at, LATE + 1);
    check("cmd8_rsp_frame", cap, 48'h08_0000_01AA_13);
    check("cmd8_oe_len", oe_cnt, 48);
    check("cmd8_oe_off", cmd_oe, 0);
    check("cmd8_idle", busy, 0);

    // Bad CRC: flagged, never offered for response
    clr();
    send_frame(48'h48_0000_01AA_85);
    check("badcrc_valid", vld_cnt, 1);
    check("badcrc_crc", v_crc, 1);
    check("badcrc_frm", v_frm, 0);
    idle(4);
    check("badcrc_rdy", rdy_seen, 0);
    check("badcrc_idle", busy, 0);
    check("badcrc_oe", oe_cnt, 0);

    // dir=0 frame is dropped silently
    clr();
    f = 48'h08_0000_01AA_13;
    for (int i = 47; i >= 1; i--) strobe(f[i]);
    check("dir0_busy_mid", busy, 1);
    strobe(f[0]);
    check("dir0_valid", vld_cnt, 0);
    check("dir0_idle", busy, 0);

    // End bit 0
    clr();
    send_frame(48'h48_0000_01AA_86);
    check("endbit_valid", vld_cnt, 1);
    check("endbit_frm", v_frm, 1);
    check("endbit_crc", v_crc, 0);
    idle(2);
    check("endbit_idle", busy, 0);

    // Response wait with no offer
    clr();
    send_frame(48'h48_0000_01AA_87);
    idle(12);
`ifdef SD_CMD_RSP_TIMEOUT_EN
    check("to_pulse", to_cnt, 1);
    check("to_at", to_at - end_at, 8);
    check("to_idle", busy, 0);
    check("to_rdy", rsp_ready, 0);
`else
    check("noto_pulse", to_cnt, 0);
    check("noto_busy", busy, 1);
    respond(6'h08, 32'h0000_01AA);
    idle(52);
    check("noto_frame", cap, 48'h08_0000_01AA_13);
    check("noto_idle", busy, 0);
`endif

    // Reset in the middle of transmit releases the line asynchronously
    clr();
    send_frame(48'h48_0000_01AA_87);
    respond(6'h08, 32'h0000_01AA);
    idle(12);
    check("midtx_oe", cmd_oe, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_oe", cmd_oe, 0);
    check("rst_async_out", cmd_out, 1);
    check("rst_async_busy", busy, 0);
    check("rst_async_index", cmd_index, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clr();
    idle(4);
    check("post_rst_oe", oe_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
